// File: rtl/rfphoenix_trace_recorder_pkg.sv
// Shared types and constants for the rfPhoenix branch-trace recorder.
// Address is the width of a committed flow-change target.
package rfPhoenixPkg;

    localparam int ADDR_W      = 32;
    localparam int TRACE_DEPTH = 1024;
    localparam int TRACE_CNT_W = 11;

    typedef logic [ADDR_W-1:0] Address;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } trace_state_t;

endpackage

// File: rtl/rfphoenix_trace_recorder_ram.sv
// Trace storage: simple dual-port RAM, one write port, registered read-first read port.
// Latency: read data one cycle after re_i; the array itself has no reset, only the read register does.
module rfphoenix_trace_ram #(
    parameter int DEPTH = 1024,
    parameter int AWID  = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AWID-1:0] waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            re_i,
    input  logic [AWID-1:0] raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-first: a pop and an overwriting push to the same slot return the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rfphoenix_trace_recorder.sv
// Branch-trace recorder: circular buffer of committed flow-change targets, popped one per rd.
// Pop latency 1 cycle; stop_on_full selects freeze vs overwrite-oldest. Optional TRACE_DEDUP_EN.
module rfphoenix_trace_recorder
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int AWID  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en,
    input  logic                   stop_on_full,
    input  logic                   trace_clr,
    input  logic                   br_commit,
    input  Address                 br_tgt,
    input  logic                   rd,
    output Address                 trace_dout,
    output logic                   trace_valid,
    output logic                   trace_empty,
    output logic [TRACE_CNT_W-1:0] trace_count,
    output logic                   trace_full,
    output logic                   trace_ovf
);

    localparam logic [TRACE_CNT_W-1:0] DEPTH_C = TRACE_CNT_W'(DEPTH);

    trace_state_t           state_q, state_d;
    logic [AWID-1:0]        wptr_q, wptr_d;
    logic [AWID-1:0]        rptr_q, rptr_d;
    logic [TRACE_CNT_W-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;

    logic empty, full, pop, push_req, dedup_ok, freeze;
    logic ram_we, ram_re;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign pop      = rd && !empty;
    assign push_req = (state_q == RUN) && br_commit && dedup_ok;

`ifdef TRACE_DEDUP_EN
    Address last_q, last_d;

    assign dedup_ok = (br_tgt != last_q);

    always_comb begin
        last_d = last_q;
        if (trace_clr) begin
            last_d = '0;
        end else if (push_req) begin
            last_d = br_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign dedup_ok = 1'b1;
`endif

    // A push that fills the buffer (or hits an already full one) without a matching pop freezes it.
    assign freeze = push_req && !pop && stop_on_full && (count_q >= DEPTH_C - 1'b1);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        if (trace_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = trace_en ? RUN : IDLE;
        end else begin
            if (pop) begin
                ram_re  = 1'b1;
                valid_d = 1'b1;
                rptr_d  = rptr_q + AWID'(1);
            end

            if (push_req) begin
                if (pop) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + AWID'(1);
                end else if (!full) begin
                    ram_we  = 1'b1;
                    wptr_d  = wptr_q + AWID'(1);
                    count_d = count_q + 1'b1;
                end else if (!stop_on_full) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + AWID'(1);
                    rptr_d = rptr_q + AWID'(1);
                    ovf_d  = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (pop) begin
                count_d = count_q - 1'b1;
            end

            if ((state_q == FROZEN) && br_commit) begin
                ovf_d = 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (trace_en) state_d = RUN;
                end
                RUN: begin
                    if (!trace_en) begin
                        state_d = IDLE;
                    end else if (freeze) begin
                        state_d = FROZEN;
                    end
                end
                FROZEN: begin
                    if (pop && trace_en) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    rfphoenix_trace_ram #(
        .DEPTH (DEPTH),
        .AWID  (AWID),
        .DW    ($bits(Address))
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (br_tgt),
        .re_i    (ram_re),
        .raddr_i (rptr_q),
        .rdata_o (trace_dout)
    );

    assign trace_valid = valid_q;
    assign trace_count = count_q;
    assign trace_empty = empty;
    assign trace_full  = full;
    assign trace_ovf   = ovf_q;

endmodule
